// File: rtl/riscv_pkg.sv
// Shared decode constants and the ID/EX control payload type.
package riscv_pkg;

    localparam int unsigned ALU_CTRL_W  = 4;
    localparam int unsigned ALU_OP_W    = 2;
    localparam int unsigned FUNCT3_W    = 3;
    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_BAD = 4'b1111;

    localparam logic [ALU_OP_W-1:0] ALUOP_MEM    = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [FUNCT3_W-1:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [FUNCT3_W-1:0] FUNCT3_OR      = 3'b110;
    localparam logic [FUNCT3_W-1:0] FUNCT3_AND     = 3'b111;

    // Width-independent control bits carried alongside the datapath.
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  illegal;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode from (alu_op, funct3, funct7_5).
module alu_ctrl_dec
    import riscv_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [FUNCT3_W-1:0]   funct3,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_control_c,
    output logic                  illegal_c
);

    always_comb begin
        alu_control_c = ALU_BAD;
        illegal_c     = 1'b1;
        case (alu_op)
            ALUOP_MEM: begin
                alu_control_c = ALU_ADD;
                illegal_c     = 1'b0;
            end
            ALUOP_BRANCH: begin
                alu_control_c = ALU_SUB;
                illegal_c     = 1'b0;
            end
            ALUOP_RTYPE: begin
                case (funct3)
                    FUNCT3_ADD_SUB: begin
                        alu_control_c = funct7_5 ? ALU_SUB : ALU_ADD;
                        illegal_c     = 1'b0;
                    end
                    FUNCT3_AND: begin
                        alu_control_c = ALU_AND;
                        illegal_c     = 1'b0;
                    end
                    FUNCT3_OR: begin
                        alu_control_c = ALU_OR;
                        illegal_c     = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: begin
                // I-type has no SUB, so funct7_5 is don't-care here
                case (funct3)
                    FUNCT3_ADD_SUB: begin
                        alu_control_c = ALU_ADD;
                        illegal_c     = 1'b0;
                    end
                    FUNCT3_AND: begin
                        alu_control_c = ALU_AND;
                        illegal_c     = 1'b0;
                    end
                    FUNCT3_OR: begin
                        alu_control_c = ALU_OR;
                        illegal_c     = 1'b0;
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Single-entry ID/EX pipeline register with operand2 mux and ALU control decode.
// Optional ID_EX_STALL_CNT_EN adds a saturating downstream-stall counter output.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [RA_W-1:0]       in_rd,
    input  logic                  in_alu_src,
    input  logic [ALU_OP_W-1:0]   in_alu_op,
    input  logic [FUNCT3_W-1:0]   in_funct3,
    input  logic                  in_funct7_5,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_operand1,
    output logic [XLEN-1:0]       out_operand2,
    output logic [ALU_CTRL_W-1:0] out_alu_control,
    output logic [XLEN-1:0]       out_rs2_data,
    output logic [RA_W-1:0]       out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_illegal
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       op1_q, op1_d;
    logic [XLEN-1:0]       op2_q, op2_d;
    logic [XLEN-1:0]       rs2_q, rs2_d;
    logic [RA_W-1:0]       rd_q, rd_d;
    ex_ctrl_t              ctrl_q, ctrl_d;
    logic [ALU_CTRL_W-1:0] dec_alu_control;
    logic                  dec_illegal;
    logic                  load;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op        (in_alu_op),
        .funct3        (in_funct3),
        .funct7_5      (in_funct7_5),
        .alu_control_c (dec_alu_control),
        .illegal_c     (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Flush beats load beats drain; payload holds unless loaded.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d          = 1'b0;
            ctrl_d.reg_write = 1'b0;
            ctrl_d.mem_read  = 1'b0;
            ctrl_d.mem_write = 1'b0;
        end else if (load) begin
            valid_d            = 1'b1;
            pc_d               = in_pc;
            op1_d              = in_rs1_data;
            op2_d              = in_alu_src ? in_imm : in_rs2_data;
            rs2_d              = in_rs2_data;
            rd_d               = in_rd;
            ctrl_d.alu_control = dec_alu_control;
            ctrl_d.illegal     = dec_illegal;
            ctrl_d.reg_write   = in_reg_write && !dec_illegal;
            ctrl_d.mem_read    = in_mem_read;
            ctrl_d.mem_write   = in_mem_write;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_operand1    = op1_q;
    assign out_operand2    = op2_q;
    assign out_alu_control = ctrl_q.alu_control;
    assign out_rs2_data    = rs2_q;
    assign out_rd          = rd_q;
    assign out_reg_write   = ctrl_q.reg_write;
    assign out_mem_read    = ctrl_q.mem_read;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_illegal     = ctrl_q.illegal;

`ifdef ID_EX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the held instruction waits on downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
